// File: rtl/cplx_pkg.sv
// Shared definitions for the complex butterfly datapath: FSM state codes,
// default part width and {re, im} field helpers.
package cplx_pkg;

    localparam int unsigned PART_LEN_DEF = 8;

    typedef logic [2:0] state_t;

    localparam state_t S_IDLE = 3'd0;
    localparam state_t S_M0   = 3'd1;
    localparam state_t S_M1   = 3'd2;
    localparam state_t S_M2   = 3'd3;
    localparam state_t S_M3   = 3'd4;
    localparam state_t S_DONE = 3'd5;

    // Real part of a packed {re, im} word at the default part width.
    function automatic logic [PART_LEN_DEF-1:0] cplx_re(input logic [2*PART_LEN_DEF-1:0] x);
        return x[2*PART_LEN_DEF-1:PART_LEN_DEF];
    endfunction

    // Imaginary part of a packed {re, im} word at the default part width.
    function automatic logic [PART_LEN_DEF-1:0] cplx_im(input logic [2*PART_LEN_DEF-1:0] x);
        return x[PART_LEN_DEF-1:0];
    endfunction

    // Pack separate parts into the {re, im} bus format.
    function automatic logic [2*PART_LEN_DEF-1:0] cplx_pack(input logic [PART_LEN_DEF-1:0] re,
                                                            input logic [PART_LEN_DEF-1:0] im);
        return {re, im};
    endfunction

endpackage

// File: rtl/cplx_mul_seq_smul.sv
// Signed PART_LEN x PART_LEN -> 2*PART_LEN combinational multiplier.
module smul
    import cplx_pkg::*;
#(
    parameter int unsigned PART_LEN = PART_LEN_DEF
) (
    input  logic signed [PART_LEN-1:0]   i_x,
    input  logic signed [PART_LEN-1:0]   i_y,
    output logic signed [2*PART_LEN-1:0] o_prod_c
);

    localparam int unsigned PROD_W = 2 * PART_LEN;

    // Operands sign-extended to full product width before multiplying.
    assign o_prod_c = PROD_W'(i_x) * PROD_W'(i_y);

endmodule

// File: rtl/cplx_mul_seq.sv
// Sequential fixed-point complex multiplier: one shared signed multiplier
// time-multiplexed over four cycles, valid/ready on both sides.
module cplx_mul_seq
    import cplx_pkg::*;
#(
    parameter int unsigned PART_LEN = PART_LEN_DEF,
    parameter int unsigned FRAC     = PART_LEN - 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [2*PART_LEN-1:0] a,
    input  logic [2*PART_LEN-1:0] b,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [2*PART_LEN-1:0] res,
    output logic                  out_valid,
    input  logic                  out_ready
);

    localparam int unsigned PROD_W = 2 * PART_LEN;
    localparam int unsigned ACC_W  = 2 * PART_LEN + 1;

    state_t r_state;
    state_t w_next_state;

    logic signed [PART_LEN-1:0] r_ar;
    logic signed [PART_LEN-1:0] r_ai;
    logic signed [PART_LEN-1:0] r_br;
    logic signed [PART_LEN-1:0] r_bi;
    logic signed [ACC_W-1:0]    r_acc;
    logic [PART_LEN-1:0]        r_re_tmp;
    logic [2*PART_LEN-1:0]      r_res;

    logic signed [PART_LEN-1:0] w_mul_x;
    logic signed [PART_LEN-1:0] w_mul_y;
    logic signed [PROD_W-1:0]   w_prod;
    logic signed [ACC_W-1:0]    w_acc_new;
    logic [PART_LEN-1:0]        w_part;
    logic                       w_accept;

    assign in_ready  = (r_state == S_IDLE) || ((r_state == S_DONE) && out_ready);
    assign out_valid = (r_state == S_DONE);
    assign res       = r_res;
    assign w_accept  = in_valid && in_ready;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic: fixed four-step schedule, DONE holds under backpressure.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_next_state = S_M0;
            S_M0:    w_next_state = S_M1;
            S_M1:    w_next_state = S_M2;
            S_M2:    w_next_state = S_M3;
            S_M3:    w_next_state = S_DONE;
            S_DONE: begin
                if (out_ready) begin
                    w_next_state = in_valid ? S_M0 : S_IDLE;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // Operand select for the shared multiplier.
    always_comb begin
        w_mul_x = r_ar;
        w_mul_y = r_br;
        case (r_state)
            S_M1: begin
                w_mul_x = r_ai;
                w_mul_y = r_bi;
            end
            S_M2: begin
                w_mul_x = r_ai;
                w_mul_y = r_br;
            end
            S_M3: begin
                w_mul_x = r_ar;
                w_mul_y = r_bi;
            end
            default: ;
        endcase
    end

    smul #(.PART_LEN(PART_LEN)) u_smul (
        .i_x      (w_mul_x),
        .i_y      (w_mul_y),
        .o_prod_c (w_prod)
    );

    // Accumulator update: M0/M2 start a new sum, M1 subtracts, M3 adds.
    always_comb begin
        w_acc_new = ACC_W'(w_prod);
        case (r_state)
            S_M1:    w_acc_new = r_acc - ACC_W'(w_prod);
            S_M3:    w_acc_new = r_acc + ACC_W'(w_prod);
            default: ;
        endcase
    end

    // Arithmetic shift floors; the cast wraps to PART_LEN bits without saturation.
    assign w_part = PART_LEN'(w_acc_new >>> FRAC);

    // Operand capture, accumulator and result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ar     <= '0;
            r_ai     <= '0;
            r_br     <= '0;
            r_bi     <= '0;
            r_acc    <= '0;
            r_re_tmp <= '0;
            r_res    <= '0;
        end else begin
            if (w_accept) begin
                r_ar <= a[2*PART_LEN-1:PART_LEN];
                r_ai <= a[PART_LEN-1:0];
                r_br <= b[2*PART_LEN-1:PART_LEN];
                r_bi <= b[PART_LEN-1:0];
            end
            case (r_state)
                S_M0, S_M2: r_acc <= w_acc_new;
                S_M1: begin
                    r_acc    <= w_acc_new;
                    r_re_tmp <= w_part;
                end
                S_M3: begin
                    r_acc <= w_acc_new;
                    r_res <= {r_re_tmp, w_part};
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cplx_mul_seq.sv
// Scoreboard bench for cplx_mul_seq with hand-computed directed vectors.
module tb_cplx_mul_seq;
    import cplx_pkg::*;

    logic        clk;
    logic        rst;
    logic [15:0] a;
    logic [15:0] b;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] res;
    logic        out_valid;
    logic        out_ready;

    int tests;
    int fails;
    logic [15:0] sb[$];

    cplx_mul_seq #(.PART_LEN(8), .FRAC(7)) dut (
        .clk       (clk),
        .rst       (rst),
        .a         (a),
        .b         (b),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .res       (res),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: compare every output handshake against the scoreboard head.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_result", 32'(res), 32'hDEAD_BEEF);
            end else begin
                logic [15:0] exp;
                exp = sb.pop_front();
                if (res !== exp)
                    $display("  re=%0d im=%0d", $signed(cplx_re(res)), $signed(cplx_im(res)));
                chk("result", 32'(res), 32'(exp));
            end
        end
    end

    // Present a pair until accepted; n is the number of edges it took.
    task automatic do_accept(input logic [15:0] ta, input logic [15:0] tb_v,
                             input logic [15:0] exp, output int n);
        bit ok;
        n  = 0;
        ok = 1'b0;
        a = ta;
        b = tb_v;
        in_valid = 1'b1;
        while (!ok && n < 20) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
            n++;
        end
        in_valid = 1'b0;
        if (ok) sb.push_back(exp);
        chk("accept", 32'(ok), 32'd1);
    endtask

    // Edges from now until out_valid is seen (bounded).
    task automatic wait_out(output int lat);
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic run_op(input string name, input logic [15:0] ta,
                          input logic [15:0] tb_v, input logic [15:0] exp);
        int n;
        int lat;
        do_accept(ta, tb_v, exp, n);
        wait_out(lat);
        chk({name, "_latency"}, 32'(lat), 32'd4);
        @(posedge clk);
        #1;
        chk({name, "_valid_drop"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int  n;
        int  lat;
        bit  seen;

        tests = 0;
        fails = 0;
        rst = 1'b1;
        a = '0;
        b = '0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_res", 32'(res), 32'd0);
        @(posedge clk);
        #1;

        // Basic, floor, and wrap vectors.
        run_op("basic", 16'h4040, 16'h40C0, 16'h4000);
        run_op("floor1", 16'h4020, 16'h007F, 16'hE03F);
        run_op("floor2", 16'hFF00, 16'h0100, 16'hFF00);
        run_op("wrap", 16'h8000, 16'h8000, 16'h8000);

        // Backpressure: hold result, then release together with a new pair.
        out_ready = 1'b0;
        do_accept(16'h4020, 16'h007F, 16'hE03F, n);
        wait_out(lat);
        chk("bp_latency", 32'(lat), 32'd4);
        for (int i = 0; i < 5; i++) begin
            chk("bp_out_valid", 32'(out_valid), 32'd1);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            chk("bp_res_stable", 32'(res), 32'hE03F);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        do_accept(16'h7F7F, 16'h7F7F, 16'h00FC, n);
        chk("bp_accept_edge", 32'(n), 32'd1);
        wait_out(lat);
        chk("b2b_latency", 32'(lat), 32'd4);
        @(posedge clk);
        #1;

        // Reset while in M2 discards the in-flight result.
        do_accept(16'h4040, 16'h40C0, 16'h4000, n);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        if (sb.size() > 0) void'(sb.pop_back());
        chk("midrst_in_ready", 32'(in_ready), 32'd1);
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_res", 32'(res), 32'd0);
        seen = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        chk("midrst_no_stale", 32'(seen), 32'd0);
        @(posedge clk);
        #1;

        // Inputs toggled during M0..M3 must not affect the captured pair.
        do_accept(16'h2010, 16'h4040, 16'h0818, n);
        for (int i = 0; i < 4; i++) begin
            a = 16'($urandom);
            b = 16'($urandom);
            in_valid = 1'b1;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        chk("ign_out_valid", 32'(out_valid), 32'd1);
        @(posedge clk);
        #1;

        repeat (3) @(posedge clk);
        #1;
        chk("sb_empty", 32'(sb.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
